// File: rtl/cabac_bypass_encoder.sv
// CABAC bypass bin encoder: updates low per bin, resolves a lead byte every 8 bins, emits bytes on valid/ready.
// Optional feature macro: CABAC_EP_BINCOUNT_EN adds the 32-bit bin_count output.
module cabac_bypass_encoder #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bin_valid,
    output logic        bin_ready,
    input  logic        bin_in,
    input  logic [8:0]  m_range,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic [7:0]  byte_data,
    output logic [31:0] m_low_out,
    output logic [4:0]  bits_left_out,
    output logic        cnt_overflow
`ifdef CABAC_EP_BINCOUNT_EN
    ,
    output logic [31:0] bin_count
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WOUT, S_EMIT} state_t;

    state_t           state_q, state_d;
    logic [31:0]      low_q, low_d;
    logic [4:0]       bits_q, bits_d;
    logic [7:0]       buf_q, buf_d;
    logic [7:0]       run_q, run_d;
    logic [7:0]       data_q, data_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             ovf_q, ovf_d;

    logic [5:0]       shamt;
    logic [31:0]      low_shift;
    logic [8:0]       lead;
    logic [4:0]       bits_add;

    always_comb begin
        shamt     = 6'd24 - {1'b0, bits_q};
        low_shift = low_q >> shamt;
        lead      = low_shift[8:0];
        bits_add  = bits_q + 5'd8;
    end

    always_comb begin
        state_d = state_q;
        low_d   = low_q;
        bits_d  = bits_q;
        buf_d   = buf_q;
        run_d   = run_q;
        data_d  = data_q;
        num_d   = num_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bin_valid) begin
                    low_d  = (low_q << 1) + {23'd0, (bin_in ? m_range : 9'd0)};
                    bits_d = bits_q - 5'd1;
                    if (bits_d < 5'd12) state_d = S_WOUT;
                end
            end
            S_WOUT: begin
                bits_d  = bits_add;
                low_d   = low_q & (32'hFFFF_FFFF >> bits_add);
                state_d = S_IDLE;
                if (lead == 9'h0FF) begin
                    // Saturate rather than wrap; the sticky flag records the loss.
                    if (num_q == '1) ovf_d = 1'b1;
                    else             num_d = num_q + CNT_W'(1);
                end else if (num_q != '0) begin
                    data_d  = buf_q + {7'd0, lead[8]};
                    run_d   = 8'hFF + {7'd0, lead[8]};
                    buf_d   = lead[7:0];
                    state_d = S_EMIT;
                end else begin
                    num_d = CNT_W'(1);
                    buf_d = lead[7:0];
                end
            end
            S_EMIT: begin
                if (byte_ready) begin
                    if (num_q > CNT_W'(1)) begin
                        data_d = run_q;
                        num_d  = num_q - CNT_W'(1);
                    end else begin
                        num_d   = CNT_W'(1);
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            low_q   <= '0;
            bits_q  <= 5'd23;
            buf_q   <= 8'hFF;
            run_q   <= 8'hFF;
            data_q  <= '0;
            num_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            low_q   <= low_d;
            bits_q  <= bits_d;
            buf_q   <= buf_d;
            run_q   <= run_d;
            data_q  <= data_d;
            num_q   <= num_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef CABAC_EP_BINCOUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              count_q <= '0;
        else if (state_q == S_IDLE && bin_valid) count_q <= count_q + 32'd1;
    end

    assign bin_count = count_q;
`endif

    assign bin_ready     = (state_q == S_IDLE);
    assign byte_valid    = (state_q == S_EMIT);
    assign byte_data     = data_q;
    assign m_low_out     = low_q;
    assign bits_left_out = bits_q;
    assign cnt_overflow  = ovf_q;

endmodule

// File: tb/tb_cabac_bypass_encoder.sv
// Randomized and directed bench for cabac_bypass_encoder against a byte-level writeOut reference model.
module tb_cabac_bypass_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        bin_valid, bin_ready, bin_in;
    logic [8:0]  m_range;
    logic        byte_valid, byte_ready;
    logic [7:0]  byte_data;
    logic [31:0] m_low_out;
    logic [4:0]  bits_left_out;
    logic        cnt_overflow;

    logic        s_valid, s_ready, s_bin, s_bvalid, s_ovf;
    logic [8:0]  s_range;
    logic [7:0]  s_data;
    logic [31:0] s_low;
    logic [4:0]  s_bits;
`ifdef CABAC_EP_BINCOUNT_EN
    logic [31:0] bin_count, s_count;
`endif

    always #5 clk = ~clk;

    cabac_bypass_encoder #(.CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .bin_valid(bin_valid), .bin_ready(bin_ready), .bin_in(bin_in),
        .m_range(m_range), .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
        .m_low_out(m_low_out), .bits_left_out(bits_left_out), .cnt_overflow(cnt_overflow)
`ifdef CABAC_EP_BINCOUNT_EN
        , .bin_count(bin_count)
`endif
    );

    cabac_bypass_encoder #(.CNT_W(2)) u_small (
        .clk(clk), .rst_n(rst_n), .bin_valid(s_valid), .bin_ready(s_ready), .bin_in(s_bin),
        .m_range(s_range), .byte_valid(s_bvalid), .byte_ready(1'b1), .byte_data(s_data),
        .m_low_out(s_low), .bits_left_out(s_bits), .cnt_overflow(s_ovf)
`ifdef CABAC_EP_BINCOUNT_EN
        , .bin_count(s_count)
`endif
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] mlow;
    int          mbits;
    logic [7:0]  mbuf;
    int          mnum;
    int unsigned n_acc;
    bit          acc;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: the arithmetic-coder writeOut loop, producing the complete byte stream.
    task automatic model_bin(input logic b, input logic [8:0] r);
        logic [31:0] lead;
        int          carry;
        mlow  = (mlow << 1) + (b ? {23'd0, r} : 32'd0);
        mbits = mbits - 1;
        if (mbits < 12) begin
            lead  = (mlow >> (24 - mbits)) & 32'h1FF;
            mbits = mbits + 8;
            mlow  = mlow & (32'hFFFF_FFFF >> mbits);
            if (lead == 32'hFF) begin
                mnum++;
            end else if (mnum > 0) begin
                carry = int'(lead >> 8);
                exp_q.push_back(8'(int'(mbuf) + carry));
                for (int k = 1; k < mnum; k++) exp_q.push_back(8'(255 + carry));
                mbuf = lead[7:0];
                mnum = 1;
            end else begin
                mnum = 1;
                mbuf = lead[7:0];
            end
        end
    endtask

    task automatic step();
        acc = 1'b0;
        if (bin_valid && bin_ready) begin
            acc = 1'b1;
            n_acc++;
            model_bin(bin_in, m_range);
        end
        if (byte_valid && byte_ready) got_q.push_back(byte_data);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bin_valid = 1'b0; bin_in = 1'b0; m_range = 9'd256; byte_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        mlow = '0; mbits = 23; mbuf = 8'hFF; mnum = 0; n_acc = 0;
        exp_q.delete(); got_q.delete();
    endtask

    task automatic send(input logic b, input logic [8:0] r);
        int t = 0;
        bin_valid = 1'b1; bin_in = b; m_range = r;
        do begin step(); t++; end while (!acc && t < 100);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        bin_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input logic b, input logic [8:0] r);
        for (int i = 0; i < n; i++) send(b, r);
    endtask

    task automatic drain();
        int t = 0;
        bin_valid = 1'b0; byte_ready = 1'b1;
        while ((byte_valid || !bin_ready) && t < 500) begin step(); t++; end
        if (t >= 500) check("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_byte"}, got_q[i], exp_q[i]);
        check({tag, "_low"}, m_low_out, mlow);
        check({tag, "_bits"}, bits_left_out, mbits);
        got_q.delete(); exp_q.delete();
    endtask

    task automatic s_send(input logic b, input logic [8:0] r);
        bit done = 1'b0;
        int t = 0;
        s_valid = 1'b1; s_bin = b; s_range = r;
        while (!done && t < 100) begin
            done = s_ready;
            @(posedge clk); @(negedge clk);
            t++;
        end
        s_valid = 1'b0;
        if (!done) check("s_send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] d0;
        int         t;
        rst_n = 1'b0; s_valid = 1'b0; s_bin = 1'b0; s_range = 9'd256;
        do_reset();

        check("rst_bin_ready", bin_ready, 1);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_data", byte_data, 0);
        check("rst_bits", bits_left_out, 23);
        check("rst_low", m_low_out, 0);
        check("rst_ovf", cnt_overflow, 0);
`ifdef CABAC_EP_BINCOUNT_EN
        check("rst_bin_count", bin_count, 0);
`endif

        send_n(12, 1'b1, 9'd256);
        drain();
        check("p2_no_byte", got_q.size(), 0);
        check("p2_bits", bits_left_out, 19);
        check("p2_low", m_low_out, 7936);
        compare_all("p2_model");
        send_n(8, 1'b1, 9'd256);
        send_n(8, 1'b0, 9'd256);
        drain();
        check("p3_nbytes", got_q.size(), 2);
        if (got_q.size() == 2) begin
            check("p3_byte0", got_q[0], 8'h7F);
            check("p3_byte1", got_q[1], 8'hFF);
        end
        compare_all("p3_model");

        do_reset();
        send_n(12, 1'b1, 9'd256);
        send_n(16, 1'b1, 9'd256);
        send_n(8, 1'b1, 9'd510);
        drain();
        check("carry_nbytes", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("carry_b0", got_q[0], 8'h80);
            check("carry_b1", got_q[1], 8'h00);
            check("carry_b2", got_q[2], 8'h00);
        end
        compare_all("carry_model");

        do_reset();
        send_n(20, 1'b1, 9'd256);
        send_n(8, 1'b0, 9'd256);
        byte_ready = 1'b0; bin_valid = 1'b1; bin_in = 1'b1; m_range = 9'd300;
        t = 0;
        while (!byte_valid && t < 10) begin step(); t++; end
        check("bp_valid", byte_valid, 1);
        d0 = byte_data;
        check("bp_first", d0, 8'h7F);
        for (int i = 0; i < 10; i++) begin
            step();
            check("bp_hold_data", byte_data, d0);
            check("bp_hold_valid", byte_valid, 1);
            check("bp_bin_ready", bin_ready, 0);
        end
        byte_ready = 1'b1;
        t = 0;
        do begin step(); t++; end while (!acc && t < 50);
        check("bp_bin_taken", acc, 1);
        bin_valid = 1'b0;
        drain();
        compare_all("bp_model");

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bin_valid  = ($urandom_range(3) != 0);
            bin_in     = 1'($urandom_range(1));
            m_range    = 9'($urandom_range(510, 256));
            byte_ready = ($urandom_range(3) != 0);
            if (i % 64 == 0 && bin_ready) begin
                check("rnd_low", m_low_out, mlow);
                check("rnd_bits", bits_left_out, mbits);
            end
            step();
        end
        drain();
        compare_all("rnd");
`ifdef CABAC_EP_BINCOUNT_EN
        check("rnd_bin_count", bin_count, n_acc);
`endif

        do_reset();
        byte_ready = 1'b0;
        send_n(20, 1'b1, 9'd256);
        send_n(8, 1'b0, 9'd256);
        t = 0;
        while (!byte_valid && t < 10) begin step(); t++; end
        check("mid_emit_reached", byte_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_bin_ready", bin_ready, 1);
        check("mid_rst_byte_valid", byte_valid, 0);
        check("mid_rst_byte_data", byte_data, 0);
        check("mid_rst_low", m_low_out, 0);
        check("mid_rst_bits", bits_left_out, 23);
        check("mid_rst_ovf", cnt_overflow, 0);
`ifdef CABAC_EP_BINCOUNT_EN
        check("mid_rst_bin_count", bin_count, 0);
`endif
        do_reset();

        for (int i = 0; i < 28; i++) s_send(1'b1, 9'd256);
        repeat (3) @(negedge clk);
        check("ovf_not_yet", s_ovf, 0);
        for (int i = 0; i < 8; i++) s_send(1'b1, 9'd256);
        repeat (3) @(negedge clk);
        check("ovf_set", s_ovf, 1);
        for (int i = 0; i < 8; i++) s_send(1'b0, 9'd256);
        repeat (10) @(negedge clk);
        check("ovf_sticky", s_ovf, 1);
        check("ovf_idle", s_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
